// File: rtl/instruction_buffer_nway.sv
// Multi-lane show-ahead instruction FIFO between fetch and decode.
// Compacts sparse write groups, presents the oldest entries first, and flushes in one cycle.
module instruction_buffer_nway #(
    parameter int P_ENTRY_W  = 102,
    parameter int P_DEPTH    = 32,
    parameter int P_DEPTH_W  = 5,
    parameter int P_IN_WAYS  = 2,
    parameter int P_OUT_WAYS = 2,
    parameter int P_STOP_TH  = 26
) (
    input  logic                             iCLOCK,
    input  logic                             inRESET,
    input  logic                             iFREE_REFRESH,
    input  logic [P_IN_WAYS-1:0]             iPREVIOUS_VALID,
    input  logic [P_IN_WAYS*P_ENTRY_W-1:0]   iPREVIOUS_DATA,
    output logic                             oPREVIOUS_FETCH_STOP,
    output logic                             oPREVIOUS_LOCK,
    output logic [P_OUT_WAYS-1:0]            oNEXT_VALID,
    output logic [P_OUT_WAYS*P_ENTRY_W-1:0]  oNEXT_DATA,
    input  logic                             iNEXT_LOCK,
    output logic [P_DEPTH_W:0]               oCOUNT
);

    localparam int CW = P_DEPTH_W + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(P_DEPTH);
    localparam logic [CW-1:0] IN_WAYS_C = CW'(P_IN_WAYS);
    localparam logic [CW-1:0] STOP_C    = CW'(P_STOP_TH);

    logic [P_ENTRY_W-1:0] mem_q [P_DEPTH];
    logic [P_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        wr_n_s, rd_n_s;
    logic                 lock_s, wr_acc_s;
    logic [P_IN_WAYS-1:0] wr_en_s;
    logic [P_DEPTH_W-1:0] wr_addr_s [P_IN_WAYS];

    // Flow-control flags depend only on registered occupancy
    always_comb begin
        lock_s               = (DEPTH_C - count_q) < IN_WAYS_C;
        oPREVIOUS_LOCK       = lock_s;
        oPREVIOUS_FETCH_STOP = count_q > STOP_C;
        oCOUNT               = count_q;
    end

    // Compact valid write lanes onto consecutive slots starting at wr_ptr
    always_comb begin
        wr_acc_s = !lock_s && !iFREE_REFRESH;
        wr_n_s   = {CW{1'b0}};
        wr_en_s  = {P_IN_WAYS{1'b0}};
        for (int k = 0; k < P_IN_WAYS; k++) begin
            wr_addr_s[k] = wr_ptr_q + wr_n_s[P_DEPTH_W-1:0];
            wr_en_s[k]   = wr_acc_s && iPREVIOUS_VALID[k];
            if (wr_en_s[k]) begin
                wr_n_s = wr_n_s + CW'(1);
            end else begin
                wr_n_s = wr_n_s;
            end
        end
    end

    // Show-ahead read lanes; decode consumes every lane presented valid
    always_comb begin
        rd_n_s      = {CW{1'b0}};
        oNEXT_VALID = {P_OUT_WAYS{1'b0}};
        oNEXT_DATA  = {(P_OUT_WAYS*P_ENTRY_W){1'b0}};
        for (int k = 0; k < P_OUT_WAYS; k++) begin
            if (count_q > CW'(k)) begin
                oNEXT_DATA[k*P_ENTRY_W +: P_ENTRY_W] = mem_q[rd_ptr_q + P_DEPTH_W'(k)];
                oNEXT_VALID[k] = !iNEXT_LOCK && !iFREE_REFRESH;
            end else begin
                oNEXT_VALID[k] = 1'b0;
            end
            rd_n_s = rd_n_s + CW'(oNEXT_VALID[k]);
        end
    end

    // Next pointers and occupancy; flush discards everything including this cycle's traffic
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (iFREE_REFRESH) begin
            wr_ptr_d = {P_DEPTH_W{1'b0}};
            rd_ptr_d = {P_DEPTH_W{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            wr_ptr_d = wr_ptr_q + wr_n_s[P_DEPTH_W-1:0];
            rd_ptr_d = rd_ptr_q + rd_n_s[P_DEPTH_W-1:0];
            count_d  = count_q + wr_n_s - rd_n_s;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            wr_ptr_q <= {P_DEPTH_W{1'b0}};
            rd_ptr_q <= {P_DEPTH_W{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset
    always_ff @(posedge iCLOCK) begin
        for (int k = 0; k < P_IN_WAYS; k++) begin
            if (wr_en_s[k]) begin
                mem_q[wr_addr_s[k]] <= iPREVIOUS_DATA[k*P_ENTRY_W +: P_ENTRY_W];
            end
        end
    end

`ifdef MIST1032ISA_SVA_ASSERTION
    // Occupancy bound check
    always_ff @(posedge iCLOCK) begin
        if (inRESET) begin
            assert (count_q <= DEPTH_C) else $error("occupancy overflow %0d", count_q);
        end
    end
`endif

endmodule

// File: tb/tb_instruction_buffer_nway.sv
// Directed + randomized bench for instruction_buffer_nway against a queue-based reference model.
module tb_instruction_buffer_nway;

    localparam int EW = 102;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [1:0]      pv;
    logic [2*EW-1:0] pd;
    logic            fstop, plock;
    logic [1:0]      nv;
    logic [2*EW-1:0] nd;
    logic            nlock;
    logic [5:0]      cnt;

    int vectors = 0;
    int errs    = 0;
    logic [EW-1:0] q[$];
    logic [31:0] pc = 32'h0;

    always #5 clk = ~clk;

    instruction_buffer_nway dut (
        .iCLOCK(clk), .inRESET(rst_n), .iFREE_REFRESH(flush),
        .iPREVIOUS_VALID(pv), .iPREVIOUS_DATA(pd),
        .oPREVIOUS_FETCH_STOP(fstop), .oPREVIOUS_LOCK(plock),
        .oNEXT_VALID(nv), .oNEXT_DATA(nd),
        .iNEXT_LOCK(nlock), .oCOUNT(cnt)
    );

    function automatic logic [EW-1:0] mk(input logic [31:0] p);
        mk = {6'($urandom), 32'($urandom), 32'($urandom), p};
    endfunction

    function automatic logic [2*EW-1:0] next_pair();
        logic [EW-1:0] e0, e1;
        e0 = mk(pc);
        e1 = mk(pc + 32'd4);
        pc = pc + 32'd8;
        return {e1, e0};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check against the model before the edge, then advance the model.
    task automatic step(input logic r, input logic [1:0] v, input logic [2*EW-1:0] d,
                        input logic nl, input logic fl, input bit chk_en);
        int c;
        logic e_lock;
        logic [1:0] e_nv;
        logic [2*EW-1:0] e_nd;
        rst_n = r; pv = v; pd = d; nlock = nl; flush = fl;
        #1;
        c      = q.size();
        e_lock = (32 - c) < 2;
        e_nv   = 2'b00;
        e_nd   = '0;
        for (int k = 0; k < 2; k++) begin
            if (c > k) begin
                e_nd[k*EW +: EW] = q[k];
                e_nv[k] = !nl && !fl;
            end
        end
        if (chk_en) begin
            chk("count", 256'(cnt), 256'(c));
            chk("lock", 256'(plock), 256'(e_lock));
            chk("stop", 256'(fstop), 256'(c > 26));
            chk("next_valid", 256'(nv), 256'(e_nv));
            chk("next_data", 256'(nd), 256'(e_nd));
        end
        @(posedge clk);
        if (!r || fl) begin
            q.delete();
        end else begin
            for (int k = 0; k < 2; k++) if (e_nv[k]) void'(q.pop_front());
            if (!e_lock) begin
                for (int k = 0; k < 2; k++) if (v[k]) q.push_back(d[k*EW +: EW]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [2*EW-1:0] pair;
        logic [EW-1:0]   tmp;
        // T1: reset held two cycles while fetch presents a full group
        step(1'b0, 2'b11, next_pair(), 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b11, next_pair(), 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b00, '0, 1'b0, 1'b0, 1'b1);

        // T2: fill with decode stalled, then keep pushing while locked
        for (int i = 0; i < 20; i++) step(1'b1, 2'b11, next_pair(), 1'b1, 1'b0, 1'b1);
        chk("t2_full_count", 256'(cnt), 256'(32));
        chk("t2_full_lock", 256'(plock), 256'(1));
        for (int i = 0; i < 18; i++) step(1'b1, 2'b00, '0, 1'b0, 1'b0, 1'b1);

        // T3: hold occupancy at 4 while streaming two in, two out across the wrap
        step(1'b1, 2'b11, next_pair(), 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'b11, next_pair(), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b1, 2'b11, next_pair(), 1'b0, 1'b0, 1'b1);
        chk("t3_count", 256'(cnt), 256'(4));
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, '0, 1'b0, 1'b0, 1'b1);

        // T4: single entry drains through lane 0 only
        step(1'b1, 2'b01, next_pair(), 1'b1, 1'b0, 1'b1);
        chk("t4_valid", 256'(nv), 256'(2'b00));
        step(1'b1, 2'b00, '0, 1'b0, 1'b0, 1'b1);
        chk("t4_empty", 256'(cnt), 256'(0));

        // T5: flush at count 10 with simultaneous write and read
        for (int i = 0; i < 5; i++) step(1'b1, 2'b11, next_pair(), 1'b1, 1'b0, 1'b1);
        step(1'b1, 2'b11, next_pair(), 1'b0, 1'b1, 1'b1);
        chk("t5_count", 256'(cnt), 256'(0));
        step(1'b1, 2'b11, next_pair(), 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'b00, '0, 1'b0, 1'b0, 1'b1);

        // T6: sparse group, lane 1 only, into an empty buffer
        tmp  = mk(32'h100);
        pair = {tmp, mk(32'hdead)};
        step(1'b1, 2'b10, pair, 1'b1, 1'b0, 1'b1);
        chk("t6_lane0_pc", 256'(nd[31:0]), 256'(32'h100));
        step(1'b1, 2'b00, '0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 199) != 0), 2'($urandom), next_pair(),
                 ($urandom_range(0, 1) == 0), ($urandom_range(0, 39) == 0), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
